// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared encodings and field ranges for the IF/ID front end
package if_id_stage_pkg;
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
endpackage

// File: rtl/if_id_stage_hazard_unit.sv
// hazard_unit: load-use hazard detection of the ID instruction against ID/EX
module hazard_unit
    import if_id_stage_pkg::*;
(
    input  logic [31:0] ifid_instr,
    input  logic        ifid_valid,
    input  logic        idex_memRead,
    input  logic [4:0]  idex_rt,
    output logic        hazard
);
    logic unused_bits;
    assign unused_bits = ^{ifid_instr[31:26], ifid_instr[15:0]};
    // Conservative match on both source fields regardless of opcode; $zero never hazards
    assign hazard = ifid_valid & idex_memRead & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_instr[RS_HI:RS_LO]) | (idex_rt == ifid_instr[RT_HI:RT_LO]));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, IF/ID register, stall/redirect control and counters
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_in,
    input  logic             imem_ready,
    input  logic             idex_memRead,
    input  logic [4:0]       idex_rt,
    input  logic [1:0]       pcSrc,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc_out,
    output logic [31:0]      ifid_pc4,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             ctrl_en,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic [31:0]      pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d, pc_plus4, target;
    logic             valid_q, valid_d, hazard, redirect;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    hazard_unit u_hazard (
        .ifid_instr  (instr_q),
        .ifid_valid  (valid_q),
        .idex_memRead(idex_memRead),
        .idex_rt     (idex_rt),
        .hazard      (hazard)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = valid_q & ~hazard & (pcSrc != PCSRC_SEQ);
    assign target   = (pcSrc == PCSRC_BR) ? branch_target :
                      (pcSrc == PCSRC_J)  ? jump_target : jr_target;

    // Next state by priority: stall, redirect flush, fetch miss bubble, normal fetch
    always_comb begin
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~&stall_cnt_q};
        end else if (redirect) begin
            pc_d        = target;
            pc4_d       = 32'd0;
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, ~&flush_cnt_q};
        end else if (!imem_ready) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_plus4;
            pc4_d   = pc_plus4;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= PC_RESET;
            pc4_q       <= 32'd0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_out     = pc_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_instr = instr_q;
    assign ifid_valid = valid_q;
    assign stall      = hazard;
    assign ctrl_en    = valid_q & ~hazard;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven directed test of the IF/ID front end
module tb_if_id_stage;
    localparam logic [31:0] IA = 32'h00A6_3820;
    localparam logic [31:0] IB = 32'h0109_5020;
    localparam logic [31:0] IC = 32'h8C0B_0000;
    localparam logic [31:0] ID = 32'h0000_0020;

    logic        clk = 1'b0, rst = 1'b1, imem_ready = 1'b0, idex_memRead = 1'b0;
    logic [31:0] instr_in = '0, branch_target = 32'h40, jump_target = 32'h80, jr_target = 32'h100;
    logic [4:0]  idex_rt = '0;
    logic [1:0]  pcSrc = '0;
    logic [31:0] pc_out, ifid_pc4, ifid_instr, s_pc, s_pc4, s_instr;
    logic        ifid_valid, ctrl_en, stall, s_valid, s_ctrl, s_stall;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  s_stall_cnt, s_flush_cnt;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .imem_ready(imem_ready),
        .idex_memRead(idex_memRead), .idex_rt(idex_rt), .pcSrc(pcSrc),
        .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
        .pc_out(pc_out), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .ctrl_en(ctrl_en), .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .instr_in(instr_in), .imem_ready(imem_ready),
        .idex_memRead(idex_memRead), .idex_rt(idex_rt), .pcSrc(pcSrc),
        .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
        .pc_out(s_pc), .ifid_pc4(s_pc4), .ifid_instr(s_instr), .ifid_valid(s_valid),
        .ctrl_en(s_ctrl), .stall(s_stall), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic        rdy;
        logic        mr;
        logic [4:0]  rt;
        logic [1:0]  src;
        logic        e_stall;
        logic        e_ctrl;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        c_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic rdy, input logic mr,
                         input logic [4:0] rt, input logic [1:0] src);
        instr_in = ins; imem_ready = rdy; idex_memRead = mr; idex_rt = rt; pcSrc = src;
    endtask

    task automatic step(input logic [31:0] ins, input logic rdy, input logic mr,
                        input logic [4:0] rt, input logic [1:0] src);
        drive(ins, rdy, mr, rt, src);
        @(posedge clk);
        #2;
    endtask

    initial begin
        vt[0]  = '{IA, 1, 0, 0, 0, 0, 0, 32'h04,  IA, 32'h04,  1, 1};
        vt[1]  = '{IB, 1, 0, 0, 0, 0, 1, 32'h08,  IB, 32'h08,  1, 1};
        vt[2]  = '{IC, 1, 0, 0, 0, 0, 1, 32'h0C,  IC, 32'h0C,  1, 1};
        vt[3]  = '{IA, 1, 0, 0, 0, 0, 1, 32'h10,  IA, 32'h10,  1, 1};
        vt[4]  = '{ID, 1, 1, 5, 0, 1, 0, 32'h10,  IA, 32'h10,  1, 1};
        vt[5]  = '{ID, 1, 0, 0, 0, 0, 1, 32'h14,  ID, 32'h14,  1, 1};
        vt[6]  = '{IB, 1, 1, 0, 0, 0, 1, 32'h18,  IB, 32'h18,  1, 1};
        vt[7]  = '{IC, 1, 0, 0, 1, 0, 1, 32'h40,  0,  0,       1, 0};
        vt[8]  = '{IA, 1, 0, 0, 1, 0, 0, 32'h44,  IA, 32'h44,  1, 1};
        vt[9]  = '{IB, 0, 0, 0, 0, 0, 1, 32'h44,  0,  0,       0, 0};
        vt[10] = '{IB, 0, 0, 0, 0, 0, 0, 32'h44,  0,  0,       0, 0};
        vt[11] = '{IB, 1, 0, 0, 0, 0, 0, 32'h48,  IB, 32'h48,  1, 1};
        vt[12] = '{IC, 1, 1, 9, 3, 1, 0, 32'h48,  IB, 32'h48,  1, 1};
        vt[13] = '{IC, 1, 0, 0, 3, 0, 1, 32'h100, 0,  0,       1, 0};
        vt[14] = '{IA, 1, 0, 0, 2, 0, 0, 32'h104, IA, 32'h104, 1, 1};
        vt[15] = '{IB, 1, 0, 0, 2, 0, 1, 32'h80,  0,  0,       1, 0};

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst pc", pc_out, 32'h0);
        chk("rst instr", ifid_instr, 32'h0);
        chk("rst pc4", ifid_pc4, 32'h0);
        chk("rst valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst stall_cnt", {16'b0, stall_cnt}, 32'h0);
        chk("rst flush_cnt", {16'b0, flush_cnt}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].instr, vt[i].rdy, vt[i].mr, vt[i].rt, vt[i].src);
            #1;
            chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
            chk($sformatf("v%0d ctrl_en", i), {31'b0, ctrl_en}, {31'b0, vt[i].e_ctrl});
            @(posedge clk);
            #2;
            chk($sformatf("v%0d pc", i), pc_out, vt[i].e_pc);
            chk($sformatf("v%0d instr", i), ifid_instr, vt[i].e_instr);
            if (vt[i].c_pc4) chk($sformatf("v%0d pc4", i), ifid_pc4, vt[i].e_pc4);
            chk($sformatf("v%0d valid", i), {31'b0, ifid_valid}, {31'b0, vt[i].e_valid});
        end
        chk("table stall_cnt", {16'b0, stall_cnt}, 32'd2);
        chk("table flush_cnt", {16'b0, flush_cnt}, 32'd3);

        step(IA, 1, 0, 0, 0);
        chk("pre-wrap pc", pc_out, 32'h84);
        jr_target = 32'hFFFF_FFFC;
        step(IC, 1, 0, 0, 3);
        chk("jr pc", pc_out, 32'hFFFF_FFFC);
        step(IB, 1, 0, 0, 0);
        chk("wrap pc", pc_out, 32'h0);
        chk("wrap pc4", ifid_pc4, 32'h0);
        chk("wrap instr", ifid_instr, IB);

        drive(IC, 1, 1, 9, 0);
        #1;
        chk("pre-rst stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst-stall pc", pc_out, 32'h0);
        chk("rst-stall instr", ifid_instr, 32'h0);
        chk("rst-stall pc4", ifid_pc4, 32'h0);
        chk("rst-stall valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst-stall stall_cnt", {16'b0, stall_cnt}, 32'h0);
        chk("rst-stall flush_cnt", {16'b0, flush_cnt}, 32'h0);
        chk("rst-stall stall", {31'b0, stall}, 32'h0);

        branch_target = 32'h40;
        step(IA, 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(IB, 1, 1, 5, 0);
            chk($sformatf("sat stall_cnt %0d", k), {30'b0, s_stall_cnt}, (k > 3) ? 32'd3 : k);
        end
        chk("long stall pc", pc_out, 32'h4);
        chk("long stall_cnt", {16'b0, stall_cnt}, 32'd5);
        for (int k = 1; k <= 4; k++) begin
            step(IA, 1, 0, 0, 0);
            step(IB, 1, 0, 0, 1);
            chk($sformatf("sat flush_cnt %0d", k), {30'b0, s_flush_cnt}, (k > 3) ? 32'd3 : k);
        end
        chk("flush_cnt", {16'b0, flush_cnt}, 32'd4);
        chk("sat stall_cnt hold", {30'b0, s_stall_cnt}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
